// File: rtl/i2c_slv_pkg.sv
// Shared types and helpers for the I2C EEPROM target: FSM states, bus events,
// majority vote and page-wrapping address increment.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  typedef struct packed {
    logic start;
    logic stop;
  } bus_evt_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Only the in-page offset bits advance; the page bits are held.
  function automatic logic [7:0] page_inc(input logic [7:0] addr, input logic [7:0] mask);
    return (addr & ~mask) | ((addr + 8'd1) & mask);
  endfunction

endpackage

// File: rtl/i2c_slv_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizers, optional 3-sample majority filter
// (I2C_SLV_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_slv_line_cond
  import i2c_slv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_scl,
  input  logic     i_sda,
  output logic     o_sda,
  output logic     o_scl_rise,
  output logic     o_scl_fall,
  output bus_evt_t o_evt
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_filt;
  logic       r_sda_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;

  // SCL must be high on both samples so a data change right at the SCL fall is not a START/STOP.
  always_comb begin
    o_evt       = '0;
    o_evt.start = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    o_evt.stop  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target modelling a small byte-addressed EEPROM (byte/page write, current,
// random and sequential read). Optional input glitch filter: I2C_SLV_GLITCH_FILTER_EN.
module i2c_eeprom_slave
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h57,
  parameter int         MEM_DEPTH = 256,
  parameter int         PAGE_SIZE = 4,
  parameter logic [7:0] INIT_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_done,
  output logic [7:0] cur_addr
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);
  localparam logic [8:0] DEPTH9    = 9'(MEM_DEPTH);

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  bus_evt_t   w_evt;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_byte_rdy;
  logic       r_wrote;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_done;
  logic [7:0] r_cur_addr;
  logic [7:0] r_mem [MEM_DEPTH];

  logic [7:0] w_byte;
  logic [8:0] w_mem_idx9;
  logic [7:0] w_mem_idx;
  logic [7:0] w_rd_byte;

  i2c_slv_line_cond u_line_cond (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_evt      (w_evt)
  );

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_mem_idx9 = {1'b0, r_cur_addr} % DEPTH9;
  assign w_mem_idx  = w_mem_idx9[7:0];
  assign w_rd_byte  = r_mem[w_mem_idx];

  // Bits are captured on SCL rise; a full byte sets r_byte_rdy and the
  // resulting state change (and any SDA drive) happens on the next SCL fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd7;
      r_shift    <= 8'h00;
      r_byte_rdy <= 1'b0;
      r_wrote    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_done  <= 1'b0;
      r_cur_addr <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= INIT_BYTE;
    end else begin
      r_wr_done <= 1'b0;
      if (w_evt.stop) begin
        r_state    <= ST_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_byte_rdy <= 1'b0;
        r_wr_done  <= r_wrote;
        r_wrote    <= 1'b0;
      end else if (w_evt.start) begin
        r_state    <= ST_DEV_ADDR;
        r_bit_cnt  <= 3'd7;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_byte_rdy <= 1'b0;
        r_wrote    <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
            if (!r_byte_rdy) begin
              r_shift <= w_byte;
              if (r_bit_cnt != 3'd0) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end else begin
                r_byte_rdy <= 1'b1;
                if (r_state == ST_DEV_ADDR && w_byte[7:1] == DEV_ADDR) r_busy <= 1'b1;
                if (r_state == ST_WORD_ADDR) r_cur_addr <= w_byte;
                if (r_state == ST_WR_DATA) begin
                  r_mem[w_mem_idx] <= w_byte;
                  r_cur_addr       <= page_inc(r_cur_addr, PAGE_MASK);
                  r_wrote          <= 1'b1;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (!r_byte_rdy) begin
              if (r_bit_cnt != 3'd0) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end else begin
                r_byte_rdy <= 1'b1;
                r_cur_addr <= r_cur_addr + 8'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (w_sda) r_state    <= ST_IGNORE;
            else       r_byte_rdy <= 1'b1;
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_DEV_ADDR: begin
            if (r_byte_rdy) begin
              r_byte_rdy <= 1'b0;
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state  <= ST_DEV_ACK;
                r_sda_oe <= 1'b1;
              end else begin
                r_state  <= ST_IGNORE;
              end
            end
          end
          ST_WORD_ADDR: begin
            if (r_byte_rdy) begin
              r_byte_rdy <= 1'b0;
              r_state    <= ST_WORD_ACK;
              r_sda_oe   <= 1'b1;
            end
          end
          ST_WR_DATA: begin
            if (r_byte_rdy) begin
              r_byte_rdy <= 1'b0;
              r_state    <= ST_WR_ACK;
              r_sda_oe   <= 1'b1;
            end
          end
          // r_shift[0] still holds the R/W bit of the address byte here.
          ST_DEV_ACK: begin
            r_bit_cnt <= 3'd7;
            if (r_shift[0]) begin
              r_state  <= ST_RD_DATA;
              r_shift  <= w_rd_byte;
              r_sda_oe <= ~w_rd_byte[7];
            end else begin
              r_state  <= ST_WORD_ADDR;
              r_sda_oe <= 1'b0;
            end
          end
          ST_WORD_ACK, ST_WR_ACK: begin
            r_state   <= ST_WR_DATA;
            r_bit_cnt <= 3'd7;
            r_sda_oe  <= 1'b0;
          end
          ST_RD_DATA: begin
            if (r_byte_rdy) begin
              r_byte_rdy <= 1'b0;
              r_state    <= ST_RD_ACK;
              r_sda_oe   <= 1'b0;
            end else begin
              r_sda_oe   <= ~r_shift[r_bit_cnt];
            end
          end
          ST_RD_ACK: begin
            if (r_byte_rdy) begin
              r_byte_rdy <= 1'b0;
              r_state    <= ST_RD_DATA;
              r_bit_cnt  <= 3'd7;
              r_shift    <= w_rd_byte;
              r_sda_oe   <= ~w_rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_done  = r_wr_done;
  assign cur_addr = r_cur_addr;

endmodule
